// File: rtl/key_nonce_loader_if.sv
// Handshake and data bundle between the key/nonce loader, its PRBS source and the consumer.
// The slave modport is the loader's view; the master modport is the environment's view.
interface key_nonce_loader_if;
    logic         i_req;
    logic [31:0]  i_prbs;
    logic         o_prbs_start;
    logic [255:0] o_key;
    logic [95:0]  o_nonce;
    logic         o_valid;
    logic         i_ready;
    logic         o_busy;
    logic [7:0]   o_set_cnt;

    modport slave (
        input  i_req, i_prbs, i_ready,
        output o_prbs_start, o_key, o_nonce, o_valid, o_busy, o_set_cnt
    );

    modport master (
        output i_req, i_prbs, i_ready,
        input  o_prbs_start, o_key, o_nonce, o_valid, o_busy, o_set_cnt
    );
endinterface

// File: rtl/key_nonce_loader.sv
// Collects eleven PRBS words into a ChaCha20 key (words 0..7) and nonce (words 8..10),
// optionally discarding SKIP_WORDS generator advances between captured words.
module key_nonce_loader #(
    parameter int unsigned SKIP_WORDS = 0
) (
    input  logic               i_aclk,
    input  logic               i_areset,
    key_nonce_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SKIP  = 2'd2,
        VALID = 2'd3
    } state_t;

    localparam logic [3:0] LAST_WORD = 4'd10;
    localparam logic [3:0] SKIP_LAST = (SKIP_WORDS > 0) ? 4'(SKIP_WORDS - 1) : 4'd0;
    localparam bit         HAS_SKIP  = (SKIP_WORDS > 0);

    state_t           state;
    state_t           state_next;
    logic [3:0]       word_idx;
    logic [3:0]       skip_cnt;
    logic [7:0][31:0] key_q;
    logic [2:0][31:0] nonce_q;
    logic [7:0]       set_cnt_q;

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.i_req) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (word_idx == LAST_WORD) begin
                    state_next = VALID;
                end else if (HAS_SKIP) begin
                    state_next = SKIP;
                end
            end
            SKIP: begin
                if (skip_cnt == SKIP_LAST) begin
                    state_next = LOAD;
                end
            end
            VALID: begin
                if (bus.i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Captured words persist through IDLE so the last set stays visible after the handshake.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            word_idx  <= '0;
            skip_cnt  <= '0;
            key_q     <= '0;
            nonce_q   <= '0;
            set_cnt_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    word_idx <= '0;
                    skip_cnt <= '0;
                end
                LOAD: begin
                    if (word_idx < 4'd8) begin
                        key_q[word_idx[2:0]] <= bus.i_prbs;
                    end else begin
                        nonce_q[word_idx[1:0]] <= bus.i_prbs;
                    end
                    word_idx <= word_idx + 4'd1;
                    skip_cnt <= '0;
                end
                SKIP: begin
                    skip_cnt <= skip_cnt + 4'd1;
                end
                VALID: begin
                    if (bus.i_ready) begin
                        set_cnt_q <= set_cnt_q + 8'd1;
                    end
                end
                default: begin
                    word_idx <= '0;
                    skip_cnt <= '0;
                end
            endcase
        end
    end

    // Strobe, busy and valid are pure state decodes, so no input reaches them combinationally.
    always_comb begin
        bus.o_prbs_start = 1'b0;
        bus.o_busy       = 1'b0;
        bus.o_valid      = 1'b0;
        unique case (state)
            LOAD, SKIP: begin
                bus.o_prbs_start = 1'b1;
                bus.o_busy       = 1'b1;
            end
            VALID: begin
                bus.o_valid = 1'b1;
            end
            default: begin
                bus.o_prbs_start = 1'b0;
            end
        endcase
    end

    assign bus.o_key     = key_q;
    assign bus.o_nonce   = nonce_q;
    assign bus.o_set_cnt = set_cnt_q;

endmodule

// File: tb/tb_key_nonce_loader.sv
// Scoreboard bench for key_nonce_loader: one instance without skips, one with two skips,
// each fed by a counting PRBS stub that advances on every strobed cycle.
module tb_key_nonce_loader;

    typedef struct {
        int           sel;
        logic [255:0] key;
        logic [95:0]  nonce;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_s     [2];
    logic         ready_s   [2];
    logic         stub_clr  [2];
    logic [31:0]  seed_s    [2];
    logic [31:0]  prbs_s    [2];
    logic         strobe_s  [2];
    logic         valid_s   [2];
    logic         busy_s    [2];
    logic [255:0] key_s     [2];
    logic [95:0]  nonce_s   [2];
    logic [7:0]   cnt_s     [2];
    logic [7:0]   exp_cnt   [2];
    logic [255:0] last_key  [2];
    logic [95:0]  last_nonce[2];
    exp_t         sbq[$];
    int           checks   = 0;
    int           failures = 0;

    key_nonce_loader_if if0 ();
    key_nonce_loader_if if2 ();

    key_nonce_loader #(.SKIP_WORDS(0)) dut0 (.i_aclk(clk), .i_areset(rst), .bus(if0.slave));
    key_nonce_loader #(.SKIP_WORDS(2)) dut2 (.i_aclk(clk), .i_areset(rst), .bus(if2.slave));

    assign if0.i_req   = req_s[0];
    assign if2.i_req   = req_s[1];
    assign if0.i_ready = ready_s[0];
    assign if2.i_ready = ready_s[1];
    assign if0.i_prbs  = prbs_s[0];
    assign if2.i_prbs  = prbs_s[1];
    assign strobe_s[0] = if0.o_prbs_start;
    assign strobe_s[1] = if2.o_prbs_start;
    assign valid_s[0]  = if0.o_valid;
    assign valid_s[1]  = if2.o_valid;
    assign busy_s[0]   = if0.o_busy;
    assign busy_s[1]   = if2.o_busy;
    assign key_s[0]    = if0.o_key;
    assign key_s[1]    = if2.o_key;
    assign nonce_s[0]  = if0.o_nonce;
    assign nonce_s[1]  = if2.o_nonce;
    assign cnt_s[0]    = if0.o_set_cnt;
    assign cnt_s[1]    = if2.o_set_cnt;

    always #5 clk = ~clk;

    // Registered PRBS stand-in: holds the seed until strobed, then counts up once per strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (stub_clr[i]) begin
                prbs_s[i] <= seed_s[i];
            end else if (strobe_s[i]) begin
                prbs_s[i] <= prbs_s[i] + 32'd1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleZero(input int sel, input string tag);
        checkOutput({tag, "_key"},    key_s[sel],    '0);
        checkOutput({tag, "_nonce"},  nonce_s[sel],  '0);
        checkOutput({tag, "_valid"},  valid_s[sel],  '0);
        checkOutput({tag, "_busy"},   busy_s[sel],   '0);
        checkOutput({tag, "_strobe"}, strobe_s[sel], '0);
        checkOutput({tag, "_cnt"},    cnt_s[sel],    '0);
    endtask

    task automatic doReset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ready_s[0] = i[0];
            ready_s[1] = ~i[0];
            tick;
        end
        ready_s[0] = 1'b0;
        ready_s[1] = 1'b0;
        rst = 1'b0;
        sbq.delete();
        for (int i = 0; i < 2; i++) begin
            exp_cnt[i]    = '0;
            last_key[i]   = '0;
            last_nonce[i] = '0;
        end
    endtask

    // Requests a set with a seeded stub, predicts all eleven words and checks the completed set.
    task automatic applyStimulus(input int sel, input logic [31:0] seed);
        exp_t        e;
        int          skips;
        int          cyc;
        int          strobes;
        logic [31:0] w;
        skips = (sel == 0) ? 0 : 2;
        seed_s[sel]   = seed;
        stub_clr[sel] = 1'b1;
        tick;
        stub_clr[sel] = 1'b0;
        e.sel   = sel;
        e.key   = '0;
        e.nonce = '0;
        for (int k = 0; k < 11; k++) begin
            w = seed + 32'(k * (skips + 1));
            if (k < 8) e.key[32*k +: 32] = w;
            else       e.nonce[32*(k-8) +: 32] = w;
        end
        sbq.push_back(e);
        req_s[sel] = 1'b1;
        tick;
        req_s[sel] = 1'b0;
        cyc     = 0;
        strobes = 0;
        while (!valid_s[sel] && cyc < 200) begin
            if (strobe_s[sel]) strobes++;
            tick;
            cyc++;
        end
        checkOutput("latency", 256'(cyc), 256'(11 + 10 * skips));
        checkOutput("strobe_cycles", 256'(strobes), 256'(11 + 10 * skips));
        checkOutput("busy_in_valid", busy_s[sel], '0);
        checkOutput("strobe_in_valid", strobe_s[sel], '0);
        e = sbq.pop_front();
        checkOutput("key", key_s[sel], e.key);
        checkOutput("nonce", nonce_s[sel], {160'd0, e.nonce});
        last_key[sel]   = e.key;
        last_nonce[sel] = e.nonce;
    endtask

    task automatic doHandshake(input int sel, input logic hold_req);
        ready_s[sel] = 1'b1;
        req_s[sel]   = hold_req;
        tick;
        ready_s[sel] = 1'b0;
        req_s[sel]   = 1'b0;
        exp_cnt[sel] = exp_cnt[sel] + 8'd1;
        checkOutput("hs_valid", valid_s[sel], '0);
        checkOutput("hs_busy", busy_s[sel], '0);
        checkOutput("hs_cnt", cnt_s[sel], exp_cnt[sel]);
        checkOutput("hs_key_kept", key_s[sel], last_key[sel]);
        checkOutput("hs_nonce_kept", nonce_s[sel], {160'd0, last_nonce[sel]});
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_s[i]    = 1'b0;
            ready_s[i]  = 1'b0;
            stub_clr[i] = 1'b1;
            seed_s[i]   = 32'd1;
        end
        doReset;
        stub_clr[0] = 1'b0;
        stub_clr[1] = 1'b0;
        checkIdleZero(0, "rst0");
        checkIdleZero(1, "rst2");

        // Ready pulses while idle must not count as handshakes.
        ready_s[0] = 1'b1;
        tick;
        tick;
        ready_s[0] = 1'b0;
        checkIdleZero(0, "idle_ready");

        applyStimulus(0, 32'd1);
        checkOutput("key_words_1to8", key_s[0],
                    {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        checkOutput("nonce_words_9to11", nonce_s[0], {32'd11, 32'd10, 32'd9});

        for (int i = 0; i < 20; i++) begin
            req_s[0] = i[0];
            tick;
            checkOutput("bp_valid", valid_s[0], 1'b1);
            checkOutput("bp_strobe", strobe_s[0], 1'b0);
            checkOutput("bp_key", key_s[0], last_key[0]);
            checkOutput("bp_nonce", nonce_s[0], {160'd0, last_nonce[0]});
        end
        req_s[0] = 1'b0;
        doHandshake(0, 1'b0);
        checkOutput("bp_cnt_one", cnt_s[0], 8'd1);

        applyStimulus(1, 32'd1);
        checkOutput("skip_nonce", nonce_s[1], {32'd31, 32'd28, 32'd25});
        checkOutput("skip_key_w0", key_s[1][31:0], 32'd1);
        doHandshake(1, 1'b1);

        seed_s[0]   = 32'h100;
        stub_clr[0] = 1'b1;
        tick;
        stub_clr[0] = 1'b0;
        req_s[0] = 1'b1;
        tick;
        req_s[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        checkOutput("midload_busy", busy_s[0], 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sbq.delete();
        for (int i = 0; i < 2; i++) begin
            exp_cnt[i]    = '0;
            last_key[i]   = '0;
            last_nonce[i] = '0;
        end
        checkIdleZero(0, "midload_rst");
        applyStimulus(0, 32'hA000_0000);
        doHandshake(0, 1'b0);

        doReset;
        for (int n = 0; n < 256; n++) begin
            applyStimulus(0, $urandom);
            doHandshake(0, 1'b1);
            if (n == 254) checkOutput("cnt_255", cnt_s[0], 8'd255);
        end
        checkOutput("cnt_wrap", cnt_s[0], 8'd0);
        tick;
        checkOutput("no_reload_busy", busy_s[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
